reg_writeback: RTL

//   Write-side driver for the 32x32 register file: queues writeback requests from the
//   ALU and memory stages and drives writeReg/writeData/regWrite.
//   The register file captures on the rising edge of regWrite, so this block emits one

---
 rtl/reg_writeback.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Register-file write driver: a small FIFO of pending writes from ALU and memory stages,
// drained by an FSM that emits one registered, glitch-free regWrite pulse per write.
// Optional WB_ZERO_GUARD_EN: requests targeting register 0 are accepted but dropped.
module reg_writeback #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          aluValid,
   input  logic [AW-1:0] aluReg,
   input  logic [DW-1:0] aluData,
   output logic          aluReady,
   input  logic          memValid,
   input  logic [AW-1:0] memReg,
   input  logic [DW-1:0] memData,
   output logic          memReady,
   output logic [AW-1:0] writeReg,
   output logic [DW-1:0] writeData,
   output logic          regWrite,
   output logic          busy,
   output logic [1:0]    fsm_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Handshake: a request transfers on a rising clock edge where valid && ready are both
   // high; producers hold valid/reg/data stable until then. Ready depends only on count
   // and memValid, never on the producer's own valid.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t state, state_next;

   logic [AW+DW-1:0] fifo [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    alu_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    free;
   logic             mem_acc;
   logic             alu_acc;
   logic             mem_enq;
   logic             alu_enq;
   logic             pop;

   assign free     = DEPTH_C - count;
   assign memReady = (free != '0);
   // Memory wins the last free slot; the ALU needs two unless memory is quiet.
   assign aluReady = (free >= CW'(2)) || ((free == CW'(1)) && !memValid);
   assign mem_acc  = memValid && memReady;
   assign alu_acc  = aluValid && aluReady;

`ifdef WB_ZERO_GUARD_EN
   assign mem_enq = mem_acc && (memReg != '0);
   assign alu_enq = alu_acc && (aluReg != '0);
`else
   assign mem_enq = mem_acc;
   assign alu_enq = alu_acc;
`endif

   // ALU entry lands behind a same-cycle memory entry, so it retires later.
   assign alu_ptr = wr_ptr + PW'(mem_enq);
   assign pop     = ((state == IDLE) || (state == HOLD)) && (count != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (mem_enq) fifo[wr_ptr] <= {memReg, memData};
         if (alu_enq) fifo[alu_ptr] <= {aluReg, aluData};
         wr_ptr <= wr_ptr + PW'(mem_enq) + PW'(alu_enq);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (count != '0) state_next = SETUP;
         SETUP:   state_next = STROBE;
         STROBE:  state_next = HOLD;
         HOLD:    state_next = (count != '0) ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // regWrite comes straight from a flop so the register file sees a clean edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else begin
         state    <= state_next;
         regWrite <= (state_next == STROBE);
         if (pop) {writeReg, writeData} <= fifo[rd_ptr];
      end
   end

   assign busy      = (count != '0) || (state != IDLE);
   assign fsm_state = state;

endmodule
